// File: rtl/vp_pkg.sv
// Shared defaults and types for the vector-product MAC accumulator.
package vp_pkg;
   localparam int VP_LANES = 3;
   localparam int VP_OC    = 8;
   localparam int VP_ACC_W = 40;
   localparam int VP_FRAC  = 8;
   localparam int PROD_W   = 32;

   // Per-lane address triple; [2] carries the output-channel index.
   typedef logic [2:0][6:0] addr_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_FLUSH,
      ST_OUTPUT,
      ST_DONE
   } state_e;
endpackage

// File: rtl/vp_mac_lane.sv
// One multiply lane: registers w*ia and its channel; zero weights never raise valid.
module vp_mac_lane
   import vp_pkg::*;
#(
   parameter int CH_W = 3
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_en,
   input  logic signed [15:0]       i_w,
   input  logic signed [15:0]       i_ia,
   input  logic [CH_W-1:0]          i_ch,
   output logic                     o_vld,
   output logic signed [PROD_W-1:0] o_prod,
   output logic [CH_W-1:0]          o_ch
);
   logic                     vld_q;
   logic signed [PROD_W-1:0] prod_q;
   logic [CH_W-1:0]          ch_q;
   logic                     live;

   assign live = i_en && (i_w != '0);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         vld_q  <= 1'b0;
         prod_q <= '0;
         ch_q   <= '0;
      end else begin
         vld_q <= live;
         if (live) begin
            prod_q <= PROD_W'(i_w) * PROD_W'(i_ia);
            ch_q   <= i_ch;
         end
      end
   end

   assign o_vld  = vld_q;
   assign o_prod = prod_q;
   assign o_ch   = ch_q;
endmodule

// File: rtl/vp_mac_accum.sv
// Per-channel MAC accumulator: 2*LANES registered products summed into OC
// accumulators, then read out channel by channel with shift and saturation.
module vp_mac_accum
   import vp_pkg::*;
#(
   parameter int LANES = VP_LANES,
   parameter int OC    = VP_OC,
   parameter int ACC_W = VP_ACC_W,
   parameter int FRAC  = VP_FRAC
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_start,
   input  logic                     i_left_ready,
   input  logic                     i_right_ready,
   input  addr_t [LANES-1:0]        i_addr_left_buffer,
   input  addr_t [LANES-1:0]        i_addr_right_buffer,
   input  logic [LANES-1:0][15:0]   i_w_data_left_buffer,
   input  logic [LANES-1:0][15:0]   i_w_data_right_buffer,
   input  logic [LANES-1:0][15:0]   i_ia_data_left_buffer,
   input  logic [LANES-1:0][15:0]   i_ia_data_right_buffer,
   input  logic                     i_finish,
   input  logic                     i_out_ready,
   output logic                     o_out_valid,
   output logic signed [15:0]       o_out_data,
   output logic [$clog2(OC)-1:0]    o_out_ch,
   output logic                     o_busy,
   output logic                     o_done
);
   localparam int CH_W = $clog2(OC);
   localparam int NP   = 2 * LANES;
   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32767);
   localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-32768);

   state_e                   state_q, state_d;
   logic                     flush_q, flush_d;
   logic [CH_W-1:0]          idx_q, idx_d;
   logic [OC-1:0][ACC_W-1:0] acc_q, acc_d;
   logic [OC-1:0][ACC_W-1:0] ch_sum;

   logic                     in_accum;
   logic [NP-1:0]            en, p_vld;
   logic [NP-1:0][PROD_W-1:0] p_prod;
   logic [NP-1:0][CH_W-1:0]  p_ch;
   logic                     unused_addr;

   assign in_accum    = (state_q == ST_ACCUM);
   assign unused_addr = ^{i_addr_left_buffer, i_addr_right_buffer};

   // Lanes 0..LANES-1 take the left buffer, the rest the right buffer.
   for (genvar l = 0; l < NP; l++) begin : g_lane
      localparam bit RIGHT = (l >= LANES);
      localparam int SL    = RIGHT ? l - LANES : l;
      logic signed [15:0] w, ia;
      logic [CH_W-1:0]    ch;

      assign w  = RIGHT ? i_w_data_right_buffer[SL]  : i_w_data_left_buffer[SL];
      assign ia = RIGHT ? i_ia_data_right_buffer[SL] : i_ia_data_left_buffer[SL];
      assign ch = RIGHT ? i_addr_right_buffer[SL][2][CH_W-1:0]
                        : i_addr_left_buffer[SL][2][CH_W-1:0];
      assign en[l] = in_accum && (RIGHT ? i_right_ready : i_left_ready);

      vp_mac_lane #(.CH_W(CH_W)) u_lane (
         .i_clk  (i_clk),
         .i_rst  (i_rst),
         .i_en   (en[l]),
         .i_w    (w),
         .i_ia   (ia),
         .i_ch   (ch),
         .o_vld  (p_vld[l]),
         .o_prod (p_prod[l]),
         .o_ch   (p_ch[l])
      );
   end

   // Stage 2: any number of lanes may land on the same channel in one cycle.
   always_comb begin
      ch_sum = '0;
      for (int c = 0; c < OC; c++)
         for (int l = 0; l < NP; l++)
            if (p_vld[l] && p_ch[l] == CH_W'(c))
               ch_sum[c] = ch_sum[c] + ACC_W'($signed(p_prod[l]));
   end

   always_comb begin
      acc_d = acc_q;
      if (state_q == ST_IDLE && i_start) begin
         acc_d = '0;
      end else begin
         for (int c = 0; c < OC; c++)
            acc_d[c] = acc_q[c] + ch_sum[c];
      end
   end

   always_comb begin
      state_d = state_q;
      flush_d = flush_q;
      idx_d   = idx_q;
      unique case (state_q)
         ST_IDLE:   if (i_start) state_d = ST_ACCUM;
         ST_ACCUM:  if (i_finish) begin
                       state_d = ST_FLUSH;
                       flush_d = 1'b0;
                    end
         ST_FLUSH:  begin
                       flush_d = 1'b1;
                       if (flush_q) begin
                          state_d = ST_OUTPUT;
                          flush_d = 1'b0;
                       end
                    end
         ST_OUTPUT: if (i_out_ready) begin
                       if (idx_q == CH_W'(OC - 1)) begin
                          idx_d   = '0;
                          state_d = ST_DONE;
                       end else begin
                          idx_d = idx_q + 1'b1;
                       end
                    end
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         flush_q <= 1'b0;
         idx_q   <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         flush_q <= flush_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
      end
   end

   logic signed [ACC_W-1:0] shifted;
   logic signed [15:0]      sat;

   assign shifted = $signed(acc_q[idx_q]) >>> FRAC;

   always_comb begin
      if (shifted > SAT_HI)      sat = 16'h7fff;
      else if (shifted < SAT_LO) sat = 16'h8000;
      else                       sat = shifted[15:0];
   end

   assign o_out_valid = (state_q == ST_OUTPUT);
   assign o_out_data  = o_out_valid ? sat : '0;
   assign o_out_ch    = idx_q;
   assign o_busy      = (state_q != ST_IDLE);
   assign o_done      = (state_q == ST_DONE);
endmodule

// File: doc/vp_mac_accum.md
VP_MAC_ACCUM -- requirements
Module: vp_mac_accum

Interface
REQ-001 SHALL have parameters: LANES, default 3, number of entries per left/right buffer; OC, default 8, number of output-channel accumulators; ACC_W, default 40, accumulator width; FRAC, default 8, right-shift applied at readout.
REQ-002 SHALL have ports: i_clk  in  1  sole clock, rising edge.
REQ-003 SHALL have ports: i_rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: i_start  in  1  one-cycle pulse that opens a tile.
REQ-005 SHALL have ports: i_left_ready, i_right_ready  in  1 each  the matching buffer holds a new group this cycle.
REQ-006 SHALL have ports: i_addr_left_buffer, i_addr_right_buffer  in  LANES x [2:0][6:0]  per-lane address triple.
REQ-007 SHALL have ports: i_w_data_left_buffer, i_w_data_right_buffer, i_ia_data_left_buffer, i_ia_data_right_buffer  in  LANES x signed 16  weight and activation operands.
REQ-008 SHALL have ports: i_finish  in  1  encoder has emitted its last group.
REQ-009 SHALL have ports: i_out_ready  in  1  consumer accepts o_out_data.
REQ-010 SHALL have ports: o_out_valid  out  1; o_out_data  out  signed 16; o_out_ch  out  $clog2(OC); o_busy  out  1; o_done  out  1 (one-cycle pulse).

Function
REQ-011 SHALL implement states IDLE, ACCUM, FLUSH, OUTPUT, DONE; IDLE->ACCUM on i_start, which also clears all accumulators.
REQ-012 SHALL in ACCUM capture left and right groups in the same cycle when both readies are high (2*LANES products per cycle); a group with ready low contributes nothing.
REQ-013 SHALL select each lane's channel as addr[2][$clog2(OC)-1:0]; lanes with w_data==0 are masked and contribute zero.
REQ-014 SHALL use pipeline stage 1 to register the full 32-bit signed product w*ia per lane.
REQ-015 SHALL use pipeline stage 2 to sum, per channel, all stage-1 products targeting that channel (any number of lanes may collide) and add the sum into that channel's ACC_W accumulator; total latency from input to accumulator update is 2 cycles.
REQ-016 SHALL let accumulators wrap modulo 2^ACC_W; no overflow flag.
REQ-017 SHALL go ACCUM->FLUSH on i_finish; a group presented in the same cycle as i_finish is still accumulated.
REQ-018 SHALL hold FLUSH exactly 2 cycles so the pipeline drains, then enter OUTPUT.
REQ-019 SHALL in OUTPUT present channels 0..OC-1 in order: o_out_data = acc >>> FRAC, saturated to [-32768, 32767], o_out_ch = index, o_out_valid = 1; the index advances only on o_out_valid && i_out_ready; data and channel stay stable while stalled.
REQ-020 SHALL after channel OC-1 is accepted enter DONE, pulse o_done for one cycle, then return to IDLE.
REQ-021 SHALL ignore i_start outside IDLE, and ignore readies and i_finish in IDLE, FLUSH, OUTPUT and DONE.
REQ-022 SHALL drive o_busy = 1 in every state except IDLE.

Reset
REQ-023 SHALL on i_rst, asynchronously and at any time including mid-tile, force IDLE, clear accumulators, pipeline registers and the channel index, and drive o_out_valid=0, o_out_data=0, o_out_ch=0, o_busy=0, o_done=0.
REQ-024 SHALL discard any in-flight products on reset; there is no partial-tile recovery.

Structure
REQ-025 SHALL place LANES, OC, ACC_W, FRAC defaults, the state enum and the packed address-triple typedef in shared package vp_pkg.
REQ-026 SHALL instantiate sub-module vp_mac_lane (registered 16x16 signed multiply with zero mask), 2*LANES instances.

Verification
REQ-027 Single group: left lane0 w=3, ia=4, addr[2]=2, then finish -> ch2 = (12>>>8) = 0; with FRAC=0, ch2 = 12 and all other channels 0.
REQ-028 Collision: left and right both valid, all 6 lanes w=2, ia=5, ch 1, FRAC=0 -> ch1 = 60.
REQ-029 Saturation: 10 groups, lane w=32767, ia=32767, FRAC=0 -> out = 32767; with ia=-32768 -> out = -32768.
REQ-030 Backpressure: hold i_out_ready low 5 cycles in OUTPUT at ch3 -> o_out_ch stays 3 with stable data; then exactly 8 transfers and one o_done.
REQ-031 Finish coincident: group w=1, ia=7, ch0 on the same cycle as i_finish, FRAC=0 -> ch0 = 7.
REQ-032 Reset mid-tile: assert i_rst during ACCUM, then new tile with a single product of 5 on ch4 -> only ch4 = 5, no stale sums.
